// File: rtl/fetch_if.sv
// fetch_if: instruction-memory request/acknowledge bus between the fetch
// stage and instruction memory.
//   if_mem_addr  fetch address, word aligned (fetch -> memory)
//   if_mem_req   fetch request                (fetch -> memory)
//   mem_if_ack   data valid for the request   (memory -> fetch)
//   mem_if_data  instruction word             (memory -> fetch)
interface fetch_if;
   logic [31:0] if_mem_addr;
   logic        if_mem_req;
   logic        mem_if_ack;
   logic [31:0] mem_if_data;

   modport master (
      output if_mem_addr,
      output if_mem_req,
      input  mem_if_ack,
      input  mem_if_data
   );

   modport slave (
      input  if_mem_addr,
      input  if_mem_req,
      output mem_if_ack,
      output mem_if_data
   );
endinterface

// File: rtl/fetch.sv
// fetch: instruction-fetch stage of the OC2 MIPS pipeline.
// Owns the PC, requests words from instruction memory over a req/ack
// handshake and presents each instruction with its PC+4 to decode. A
// one-entry skid buffer holds a word acked while decode stalls. Redirects
// from decode are applied when the delay slot is transferred.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   fw_if_id_stall        decode stall, IF/ID must hold
//   id_if_selfontepc      take redirect target
//   id_if_seltipopc       target select (00 imd, 01 rega, 10 index, 11 none)
//   id_if_rega/pcimd2ext/pcindex   redirect targets
//   if_id_instrucao/proximopc/valid  IF/ID register outputs
//   mem                   instruction-memory bus (fetch_if.master)
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fw_if_id_stall,
   input  logic        id_if_selfontepc,
   input  logic [1:0]  id_if_seltipopc,
   input  logic [31:0] id_if_rega,
   input  logic [31:0] id_if_pcimd2ext,
   input  logic [31:0] id_if_pcindex,
   output logic [31:0] if_id_instrucao,
   output logic [31:0] if_id_proximopc,
   output logic        if_id_valid,
   fetch_if.master     mem
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] skid_q, skid_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] prox_q, prox_d;
   logic        valid_q, valid_d;

   logic        xfer;
   logic [31:0] xfer_word;
   logic [31:0] pc_plus4;
   logic [31:0] target;
   logic [31:0] next_pc;

   assign pc_plus4 = pc_q + 32'd4;

   // Redirect target selection; only consulted on a transfer edge, so the
   // redirect lands after the delay slot held behind the branch.
   always_comb begin
      target = pc_plus4;
      unique case (id_if_seltipopc)
         2'b00:   target = id_if_pcimd2ext;
         2'b01:   target = id_if_rega;
         2'b10:   target = id_if_pcindex;
         default: target = pc_plus4;
      endcase
      if (id_if_selfontepc && (id_if_seltipopc != 2'b11))
         next_pc = {target[31:2], 2'b00};
      else
         next_pc = pc_plus4;
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      skid_d    = skid_q;
      instr_d   = instr_q;
      prox_d    = prox_q;
      valid_d   = valid_q;
      xfer      = 1'b0;
      xfer_word = mem.mem_if_data;

      unique case (state_q)
         ST_IDLE: state_d = ST_REQ;
         ST_REQ: begin
            if (mem.mem_if_ack) begin
               if (!fw_if_id_stall) begin
                  xfer = 1'b1;
               end else begin
                  skid_d  = mem.mem_if_data;
                  state_d = ST_HOLD;
               end
            end
         end
         ST_HOLD: begin
            // pc still addresses the buffered word, so PC+4 and redirect
            // evaluation are identical to a direct transfer.
            if (!fw_if_id_stall) begin
               xfer      = 1'b1;
               xfer_word = skid_q;
               state_d   = ST_REQ;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (xfer) begin
         instr_d = xfer_word;
         prox_d  = pc_plus4;
         valid_d = 1'b1;
         pc_d    = next_pc;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         skid_q  <= '0;
         instr_q <= NOP;
         prox_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         skid_q  <= skid_d;
         instr_q <= instr_d;
         prox_q  <= prox_d;
         valid_q <= valid_d;
      end
   end

   assign mem.if_mem_addr = pc_q;
   assign mem.if_mem_req  = (state_q == ST_REQ);
   assign if_id_instrucao = instr_q;
   assign if_id_proximopc = prox_q;
   assign if_id_valid     = valid_q;

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed testbench for the fetch stage.
module tb_fetch;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        fw_if_id_stall = 1'b0;
   logic        id_if_selfontepc = 1'b0;
   logic [1:0]  id_if_seltipopc = 2'b11;
   logic [31:0] id_if_rega = '0;
   logic [31:0] id_if_pcimd2ext = '0;
   logic [31:0] id_if_pcindex = '0;
   logic [31:0] if_id_instrucao;
   logic [31:0] if_id_proximopc;
   logic        if_id_valid;

   fetch_if mem ();

   fetch #(
      .RESET_PC (32'h0000_0000),
      .NOP      (32'h0000_0000)
   ) dut (
      .clock            (clock),
      .reset            (reset),
      .fw_if_id_stall   (fw_if_id_stall),
      .id_if_selfontepc (id_if_selfontepc),
      .id_if_seltipopc  (id_if_seltipopc),
      .id_if_rega       (id_if_rega),
      .id_if_pcimd2ext  (id_if_pcimd2ext),
      .id_if_pcindex    (id_if_pcindex),
      .if_id_instrucao  (if_id_instrucao),
      .if_id_proximopc  (if_id_proximopc),
      .if_id_valid      (if_id_valid),
      .mem              (mem.master)
   );

   always #5 clock = ~clock;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check_ifid(input string tag, input logic [31:0] instr,
                             input logic [31:0] prox, input logic valid);
      check_eq({tag, ".instr"}, if_id_instrucao, instr);
      check_eq({tag, ".prox"},  if_id_proximopc, prox);
      check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
   endtask

   task automatic check_mem(input string tag, input logic req, input logic [31:0] addr);
      check_eq({tag, ".req"},  {31'd0, mem.if_mem_req}, {31'd0, req});
      check_eq({tag, ".addr"}, mem.if_mem_addr, addr);
   endtask

   task automatic ack_word(input logic [31:0] w);
      mem.mem_if_ack  = 1'b1;
      mem.mem_if_data = w;
   endtask

   initial begin
      mem.mem_if_ack  = 1'b0;
      mem.mem_if_data = '0;

      // 1. reset held with clock running, then release
      tick;
      tick;
      check_mem("rst", 1'b0, 32'h0);
      check_ifid("rst", 32'h0, 32'h0, 1'b0);
      reset = 1'b1;
      tick;
      check_mem("start", 1'b1, 32'h0);

      // 2. zero-wait streaming
      ack_word(32'hA500_0000);
      tick;
      check_ifid("s0", 32'hA500_0000, 32'h4, 1'b1);
      check_mem("s0", 1'b1, 32'h4);
      ack_word(32'hA500_0004);
      tick;
      check_ifid("s1", 32'hA500_0004, 32'h8, 1'b1);
      ack_word(32'hA500_0008);
      tick;
      check_ifid("s2", 32'hA500_0008, 32'hC, 1'b1);
      check_mem("s2", 1'b1, 32'hC);

      // restart so the wait-state case runs at 0x4
      reset = 1'b0;
      mem.mem_if_ack = 1'b0;
      tick;
      reset = 1'b1;
      tick;
      ack_word(32'hA500_0000);
      tick;
      check_mem("w0", 1'b1, 32'h4);

      // 3. three wait cycles on 0x4
      mem.mem_if_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         check_mem("wait", 1'b1, 32'h4);
         check_ifid("wait", 32'hA500_0000, 32'h4, 1'b1);
      end
      ack_word(32'hA500_0004);
      tick;
      check_ifid("wack", 32'hA500_0004, 32'h8, 1'b1);
      check_mem("wack", 1'b1, 32'h8);

      // 4. stall during ack of 0x8
      fw_if_id_stall = 1'b1;
      ack_word(32'h1234_5678);
      tick;
      check_mem("hold", 1'b0, 32'h8);
      check_ifid("hold", 32'hA500_0004, 32'h8, 1'b1);
      ack_word(32'hDEAD_BEEF);
      tick;
      check_mem("hold2", 1'b0, 32'h8);
      check_ifid("hold2", 32'hA500_0004, 32'h8, 1'b1);
      fw_if_id_stall = 1'b0;
      tick;
      check_ifid("drain", 32'h1234_5678, 32'hC, 1'b1);
      check_mem("drain", 1'b1, 32'hC);

      // 5. redirects
      ack_word(32'hA500_000C);
      tick;
      check_mem("pre", 1'b1, 32'h10);
      ack_word(32'h1000_000F);
      tick;
      check_ifid("br", 32'h1000_000F, 32'h14, 1'b1);
      id_if_selfontepc = 1'b1;
      id_if_seltipopc  = 2'b00;
      id_if_pcimd2ext  = 32'h0000_0040;
      ack_word(32'hA500_0014);
      tick;
      check_ifid("dslot", 32'hA500_0014, 32'h18, 1'b1);
      check_mem("br", 1'b1, 32'h40);
      id_if_selfontepc = 1'b0;
      id_if_seltipopc  = 2'b11;
      ack_word(32'hA500_0040);
      tick;
      check_mem("seq", 1'b1, 32'h44);
      // redirect with no transfer is ignored
      mem.mem_if_ack   = 1'b0;
      id_if_selfontepc = 1'b1;
      id_if_seltipopc  = 2'b00;
      id_if_pcimd2ext  = 32'h0000_0100;
      tick;
      check_mem("noxfer", 1'b1, 32'h44);
      id_if_seltipopc = 2'b01;
      id_if_rega      = 32'h0000_0083;
      ack_word(32'hA500_0044);
      tick;
      check_mem("jr", 1'b1, 32'h80);
      check_ifid("jr", 32'hA500_0044, 32'h48, 1'b1);
      id_if_seltipopc = 2'b11;
      ack_word(32'hA500_0080);
      tick;
      check_mem("sel11", 1'b1, 32'h84);
      id_if_seltipopc = 2'b10;
      id_if_pcindex   = 32'hFFFF_FFFF;
      ack_word(32'hA500_0084);
      tick;
      check_mem("jidx", 1'b1, 32'hFFFF_FFFC);
      id_if_selfontepc = 1'b0;
      id_if_seltipopc  = 2'b11;
      ack_word(32'h5A5A_5A5A);
      tick;
      check_ifid("wrap", 32'h5A5A_5A5A, 32'h0, 1'b1);
      check_mem("wrap", 1'b1, 32'h0);

      // 6. reset during a wait at 0x20
      id_if_selfontepc = 1'b1;
      id_if_seltipopc  = 2'b10;
      id_if_pcindex    = 32'h0000_0020;
      ack_word(32'hA500_0000);
      tick;
      id_if_selfontepc = 1'b0;
      id_if_seltipopc  = 2'b11;
      mem.mem_if_ack   = 1'b0;
      tick;
      check_mem("w20", 1'b1, 32'h20);
      reset = 1'b0;
      #2;
      check_mem("arst", 1'b0, 32'h0);
      check_ifid("arst", 32'h0, 32'h0, 1'b0);
      tick;
      reset = 1'b1;
      ack_word(32'h7777_7777);
      tick;
      check_mem("idleack", 1'b1, 32'h0);
      check_ifid("idleack", 32'h0, 32'h0, 1'b0);
      ack_word(32'hA500_0000);
      tick;
      check_ifid("restart", 32'hA500_0000, 32'h4, 1'b1);
      check_mem("restart", 1'b1, 32'h4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the OC2 MIPS pipeline, the producer side of the IF/ID interface consumed by the decode stage. It owns the PC, issues word requests to instruction memory over a req/ack handshake and presents each instruction with its PC+4 to decode. It holds one instruction while decode stalls and applies redirects from decode (branch, JR/JALR, J/JAL) after the delay slot.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset
- NOP, 32'h0000_0000, instruction word presented when IF/ID holds nothing (sll r0,r0,0)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- fw_if_id_stall  in  1  decode stall; IF/ID must hold
- id_if_selfontepc  in  1  1 = take redirect target
- id_if_seltipopc  in  2  target select: 00 pcimd2ext, 01 rega, 10 pcindex, 11 none
- id_if_rega  in  32  JR/JALR target
- id_if_pcimd2ext  in  32  branch target
- id_if_pcindex  in  32  J/JAL target
- if_id_instrucao  out  32  instruction in IF/ID
- if_id_proximopc  out  32  address of that instruction + 4
- if_id_valid  out  1  IF/ID holds a fetched instruction
- if_mem_addr  out  32  fetch address, word aligned
- if_mem_req  out  1  fetch request
- mem_if_ack  in  1  data valid for the current request
- mem_if_data  in  32  instruction word

## Operation
- Registers:
  - pc (32)
  - state: IDLE, REQ, HOLD
  - buf (32, one-entry skid buffer)
  - IF/ID outputs
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, state=IDLE.
  - if_mem_req=0, if_mem_addr=RESET_PC.
  - if_id_instrucao=NOP, if_id_proximopc=0, if_id_valid=0, buf=0.
- if_mem_addr = pc, if_mem_req = (state==REQ). Both are registered/state-derived; there is no combinational input-to-output path.
- IDLE goes to REQ at the first rising edge after reset is released.
- REQ, edge with mem_if_ack=1:
  - Stall=0: transfer mem_if_data into IF/ID. Stay in REQ.
  - Stall=1: buf<=mem_if_data, go to HOLD. pc and IF/ID are unchanged.
- REQ, edge with ack=0: nothing changes. The request stays asserted at the same address, whether or not stall is set.
- HOLD: req=0. At the first edge with stall=0, transfer buf into IF/ID and go to REQ.
- Transfer (word w):
  - if_id_instrucao<=w, if_id_proximopc<=pc+4, if_id_valid<=1.
  - pc<=next_pc.
- next_pc is evaluated at the transfer edge:
  - If selfontepc=1 and seltipopc≠11: the selected target with bits [1:0] forced to 00.
  - Otherwise pc+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- Delay slot: the redirect belongs to the branch in IF/ID, so it is applied when the next word (the delay slot) is transferred. The delay slot is never squashed. Redirect inputs are ignored on edges without a transfer.
- mem_if_ack is ignored in IDLE and HOLD.
- Stall with no transfer: IF/ID holds its value (valid included).

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per cycle.
  - The request for A is issued after edge k and acked at edge k+1.
  - A is in IF/ID after edge k+1, and the request for next_pc is visible the same cycle.
- N wait cycles give latency N+1 edges per instruction. The address is stable throughout.
- A stall-during-ack costs no refetch: buf drains at the first edge with stall=0, and the next request follows in the same cycle.
- A reset assertion takes effect immediately, not at a clock edge. An ack arriving after reset, while in IDLE, is dropped.

## Test plan
1. Reset and start.
   - Hold reset=0 with the clock running: req=0, addr=0, instr=0, proximopc=0, valid=0.
   - Release reset: req=1 and addr=0x0 after the next edge.
2. Streaming with zero wait.
   - Stimulus: ack=1 every cycle, data = addr ^ 0xA500_0000.
   - IF/ID must hold 0xA500_0000, 0xA500_0004 and 0xA500_0008 on consecutive cycles, with proximopc 0x4, 0x8, 0xC.
3. Wait states.
   - Stimulus: ack for 0x4 arrives 3 cycles after the request.
   - addr must stay 0x4 and req must stay 1 for all 3 cycles, and IF/ID must keep the word from 0x0.
   - At the ack edge, IF/ID loads the new word and addr becomes 0x8.
4. Stall capture.
   - Stimulus: stall=1 at the ack edge for 0x8, with data 0x1234_5678.
   - Required: state HOLD, req=0, IF/ID unchanged, and ack pulses are ignored.
   - Drop stall: at the next edge IF/ID=0x1234_5678 with proximopc=0xC, and then req=1 with addr=0xC.
5. Redirects.
   - Branch: the branch at 0x10 is in IF/ID with selfontepc=1, seltipopc=00, pcimd2ext=0x40. The delay slot 0x14 is transferred and the next addr is 0x40.
   - JR: seltipopc=01 with rega=0x83 gives next addr 0x80.
   - Ignored redirect: seltipopc=11 gives next addr 0x18.
6. Reset during a wait.
   - Stimulus: assert reset between edges while req=1 at 0x20.
   - Outputs return to reset values before the next edge. An ack after release and before REQ is ignored, and fetch restarts at 0x0.
